// File: rtl/apb_rr_master.sv
// apb_rr_master: two requester ports sharing one APB bus.
// A fair two-way round-robin arbiter feeds a three-state APB sequencer
// (IDLE / SETUP / ACCESS, no wait states). Each accepted command produces
// exactly one single-cycle response on the port that issued it.
//
// Handshake: a command moves from requester to master in the cycle where
// reqN_valid && reqN_ready are both high at the rising edge of pclk. The
// requester must hold valid/write/addr/wdata stable until that happens;
// reqN_ready is combinational and only ever high in IDLE or ACCESS while
// preset is low. Responses have no backpressure: rspN_valid is a one-cycle
// strobe that the requester must consume when it appears.
module apb_rr_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              pclk,
  input  logic              preset,
  // requester port 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  // requester port 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  // APB master side
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  // current sequencer state, for observation only
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // last_grant = id of the port granted most recently; resets to 1 so
  // port 0 wins the first contention after reset.
  logic last_grant;
  // id of the port owning the transfer currently on the bus
  logic cur_port;

  logic arb_win;
  logic grant0;
  logic grant1;
  logic grant_any;
  logic finishing;

  // Arbitration: a new command may only be taken when the bus is about to
  // be free for a SETUP phase, i.e. in IDLE or in the last (ACCESS) cycle.
  always_comb begin
    arb_win   = !preset && (state == ST_IDLE || state == ST_ACCESS);
    grant0    = arb_win && req0_valid && (!req1_valid || last_grant);
    grant1    = arb_win && req1_valid && (!req0_valid || !last_grant);
    grant_any = grant0 || grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign fsm_state  = state;

  // A transfer completes at the edge that ends its ACCESS cycle.
  assign finishing = (state == ST_ACCESS);

  // Sequencer state register.
  always_ff @(posedge pclk) begin
    if (preset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and APB phase outputs.
  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        psel      = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        state_nxt = grant_any ? ST_SETUP : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the granted command; address/data/direction hold until the
  // next grant, even while the bus sits in IDLE.
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr      <= '0;
      pwdata     <= '0;
      pwrite     <= 1'b0;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
    end else if (grant0) begin
      paddr      <= req0_addr;
      pwdata     <= req0_wdata;
      pwrite     <= req0_write;
      last_grant <= 1'b0;
      cur_port   <= 1'b0;
    end else if (grant1) begin
      paddr      <= req1_addr;
      pwdata     <= req1_wdata;
      pwrite     <= req1_write;
      last_grant <= 1'b1;
      cur_port   <= 1'b1;
    end
  end

  // Response strobes: one cycle on the owning port; read data only for
  // reads, zero otherwise. pwrite still describes the finishing transfer
  // here because a new grant only overwrites it at this same edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= finishing && !cur_port;
      rsp1_valid <= finishing &&  cur_port;
      rsp0_rdata <= (finishing && !cur_port && !pwrite) ? prdata : '0;
      rsp1_rdata <= (finishing &&  cur_port && !pwrite) ? prdata : '0;
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed table, hand-written corner sequences
// and a randomized phase, all checked cycle by cycle against a
// transaction-timing reference model.
module tb_apb_rr_master;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic          preset;
  logic [1:0]    v, w, rdy, rv;
  logic [AW-1:0] a[2];
  logic [DW-1:0] d[2];
  logic [DW-1:0] rd[2];
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pwrite, psel, penable;
  logic [1:0]    fsm_state;

  apb_rr_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk(pclk), .preset(preset),
    .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_write(w[0]),
    .req0_addr(a[0]), .req0_wdata(d[0]),
    .rsp0_valid(rv[0]), .rsp0_rdata(rd[0]),
    .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_write(w[1]),
    .req1_addr(a[1]), .req1_wdata(d[1]),
    .rsp1_valid(rv[1]), .rsp1_rdata(rd[1]),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata),
    .fsm_state(fsm_state)
  );

  // ---------------- bench state ----------------
  int passed = 0;
  int total  = 0;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;
  cmd_t cq0[$];
  cmd_t cq1[$];

  // manual-mode values, copied onto the DUT inputs each cycle
  logic          m_rst;
  logic [1:0]    mv, mw;
  logic [AW-1:0] ma[2];
  logic [DW-1:0] md[2];
  logic [DW-1:0] m_prd;
  logic          auto_mode;
  int            gap_pct, drop_pct;
  logic [1:0]    acc;

  // scoreboard: expected port order of responses in directed sequences
  logic [1:0] exp_q[$];
  logic       use_q;
  int         rsp_cnt[2];
  int         psel_run, psel_max, psel_cnt;

  // reference model: grants made 1, 2, 3 cycles ago
  logic          hv[1:3], hp[1:3], hw[1:3];
  logic [DW-1:0] hprd[1:3];
  logic          e_last, e_pwrite;
  logic [AW-1:0] e_paddr;
  logic [DW-1:0] e_pwdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model + per-cycle check ----------------
  task automatic model_check();
    logic [1:0]    er;
    logic [1:0]    erv;
    logic [DW-1:0] erd[2];
    er[0] = !preset && !hv[1] && v[0] && (!v[1] || e_last != 1'b0);
    er[1] = !preset && !hv[1] && v[1] && (!v[0] || e_last != 1'b1);
    for (int n = 0; n < 2; n++) begin
      erv[n] = hv[3] && (hp[3] == n[0]);
      erd[n] = (erv[n] && !hw[3]) ? hprd[3] : '0;
    end
    chk("psel",    psel,    hv[1] | hv[2]);
    chk("penable", penable, hv[2]);
    chk("paddr",   paddr,   e_paddr);
    chk("pwdata",  pwdata,  e_pwdata);
    chk("pwrite",  pwrite,  e_pwrite);
    chk("ready0",  rdy[0],  er[0]);
    chk("ready1",  rdy[1],  er[1]);
    chk("rsp0_valid", rv[0], erv[0]);
    chk("rsp1_valid", rv[1], erv[1]);
    chk("rsp0_rdata", rd[0], erd[0]);
    chk("rsp1_rdata", rd[1], erd[1]);

    if (psel === 1'b1) begin psel_run++; psel_cnt++; end
    else psel_run = 0;
    if (psel_run > psel_max) psel_max = psel_run;
    for (int n = 0; n < 2; n++) begin
      acc[n] = v[n] && rdy[n];
      if (rv[n] === 1'b1) begin
        rsp_cnt[n]++;
        if (use_q) begin
          if (exp_q.size() == 0) chk("rsp_unexpected_port", n, 2);
          else chk("grant_order", n, exp_q.pop_front());
        end
      end
    end

    if (preset) begin
      for (int i = 1; i <= 3; i++) hv[i] = 1'b0;
      e_last = 1'b1; e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0;
    end else begin
      if (hv[2]) hprd[2] = prdata;
      hv[3] = hv[2]; hp[3] = hp[2]; hw[3] = hw[2]; hprd[3] = hprd[2];
      hv[2] = hv[1]; hp[2] = hp[1]; hw[2] = hw[1]; hprd[2] = '0;
      hv[1] = er[0] | er[1];
      hp[1] = er[1];
      hw[1] = er[1] ? w[1] : w[0];
      if (hv[1]) begin
        e_last   = hp[1];
        e_paddr  = a[hp[1]];
        e_pwdata = d[hp[1]];
        e_pwrite = hw[1];
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic auto_port(input int n);
    cmd_t c;
    int   sz;
    sz = (n == 0) ? cq0.size() : cq1.size();
    if (v[n] && acc[n]) begin
      if (n == 0) void'(cq0.pop_front());
      else        void'(cq1.pop_front());
      v[n] = 1'b0;
      sz--;
    end else if (v[n] && $urandom_range(0, 99) < drop_pct) begin
      v[n] = 1'b0;  // withdrawn before acceptance: must never be issued
      return;
    end
    if (!v[n] && sz > 0 && $urandom_range(0, 99) >= gap_pct) begin
      c    = (n == 0) ? cq0[0] : cq1[0];
      v[n] = 1'b1;
      w[n] = c.write;
      a[n] = c.addr;
      d[n] = c.wdata;
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    preset = m_rst;
    if (auto_mode) begin
      auto_port(0);
      auto_port(1);
      prdata = $urandom;
    end else begin
      v = mv; w = mw; a = ma; d = md;
      prdata = m_prd;
    end
    @(negedge pclk);
    model_check();
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.write = 1'($urandom_range(0, 1));
    c.addr  = $urandom;
    c.wdata = $urandom;
    return c;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    int            port;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prd;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int rc0;
    preset = 1'b1; v = '0; w = '0; prdata = '0;
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    m_rst = 1'b1; mv = '0; mw = '0; m_prd = '0;
    ma[0] = '0; ma[1] = '0; md[0] = '0; md[1] = '0;
    auto_mode = 1'b0; gap_pct = 0; drop_pct = 0; acc = '0; use_q = 1'b0;
    rsp_cnt[0] = 0; rsp_cnt[1] = 0; psel_run = 0; psel_max = 0; psel_cnt = 0;
    for (int i = 1; i <= 3; i++) begin hv[i] = 0; hp[i] = 0; hw[i] = 0; hprd[i] = '0; end
    e_last = 1'b1; e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;

    tbl[0] = '{0, 1'b1, 32'h0000_000C, 32'h0000_00A5, 32'hCAFE_F00D, 32'h0};
    tbl[1] = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 32'h1234_5678};
    tbl[2] = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[3] = '{1, 1'b1, 32'h0000_0008, 32'h0000_55AA, 32'h0BAD_0BAD, 32'h0};

    // reset state
    repeat (3) step();
    chk("reset_psel", psel, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_ready", rdy, 0);
    m_rst = 1'b0;
    step();

    // single transfers from IDLE
    foreach (tbl[i]) begin
      int p;
      p = tbl[i].port;
      m_prd = tbl[i].prd;
      mv[p] = 1'b1; mw[p] = tbl[i].write; ma[p] = tbl[i].addr; md[p] = tbl[i].wdata;
      step();                                   // T
      chk("tbl_ready", rdy[p], 1);
      mv = '0;
      step();                                   // T+1 SETUP
      chk("tbl_setup", {psel, penable, pwrite, paddr}, {1'b1, 1'b0, tbl[i].write, tbl[i].addr});
      chk("tbl_pwdata", pwdata, tbl[i].wdata);
      step();                                   // T+2 ACCESS
      chk("tbl_access", {psel, penable}, 2'b11);
      step();                                   // T+3
      chk("tbl_rsp_valid", {rv[p], rv[1-p], psel}, 3'b100);
      chk("tbl_rsp_rdata", rd[p], tbl[i].exp_rdata);
      step();
    end

    // contention from reset release: 4 commands per port
    m_rst = 1'b1;
    auto_mode = 1'b1; gap_pct = 0; drop_pct = 0;
    for (int i = 0; i < 4; i++) begin
      cq0.push_back(rnd_cmd());
      cq1.push_back(rnd_cmd());
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
    end
    use_q = 1'b1;
    step();
    psel_max = 0; psel_cnt = 0; rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    m_rst = 1'b0;
    repeat (22) step();
    chk("contend_psel_run", psel_max, 16);
    chk("contend_psel_cnt", psel_cnt, 16);
    chk("contend_rsp0", rsp_cnt[0], 4);
    chk("contend_rsp1", rsp_cnt[1], 4);
    chk("contend_queue_left", exp_q.size(), 0);

    // fairness: port 1 alone three times, then both
    for (int i = 0; i < 3; i++) begin cq1.push_back(rnd_cmd()); exp_q.push_back(2'd1); end
    repeat (10) step();
    cq0.push_back(rnd_cmd()); cq1.push_back(rnd_cmd());
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    repeat (10) step();
    chk("fair_queue_left", exp_q.size(), 0);
    use_q = 1'b0;

    // handshake stall: port 0 raises valid during SETUP
    auto_mode = 1'b0; mv = '0;
    step();
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    mv[1] = 1'b1; mw[1] = 1'b0; ma[1] = 32'h20; m_prd = 32'h5555_AAAA;
    step();                                     // T: port 1 granted
    chk("stall_p1_ready", rdy[1], 1);
    mv[1] = 1'b0; mv[0] = 1'b1; mw[0] = 1'b1; ma[0] = 32'h24; md[0] = 32'h77;
    step();                                     // SETUP
    chk("stall_ready_setup", rdy[0], 0);
    step();                                     // ACCESS
    chk("stall_ready_access", rdy[0], 1);
    mv[0] = 1'b0;
    repeat (5) step();
    chk("stall_rsp0_once", rsp_cnt[0], 1);
    chk("stall_rsp1_once", rsp_cnt[1], 1);

    // reset during ACCESS of a read, then contention
    mv[0] = 1'b1; mw[0] = 1'b0; ma[0] = 32'h30; m_prd = 32'h1111_2222;
    step();                                     // T: port 0 granted
    mv[0] = 1'b0;
    step();                                     // SETUP
    m_rst = 1'b1;
    step();                                     // ACCESS with reset high
    m_rst = 1'b0;
    rc0 = rsp_cnt[0];
    mv = 2'b11; mw = 2'b00; ma[0] = 32'h40; ma[1] = 32'h44;
    step();
    chk("rst_access_phase", {psel, penable, rv}, 4'b0000);
    chk("rst_contend_grant", rdy, 2'b01);
    mv[0] = 1'b0;
    step();
    step();                                     // port 1 granted in ACCESS
    mv[1] = 1'b0;
    repeat (4) step();
    chk("rst_no_aborted_rsp", rsp_cnt[0], rc0 + 1);

    // randomized traffic with occasional reset
    auto_mode = 1'b1; gap_pct = 30; drop_pct = 5;
    for (int c = 0; c < 800; c++) begin
      if (cq0.size() < 2) cq0.push_back(rnd_cmd());
      if (cq1.size() < 2) cq1.push_back(rnd_cmd());
      m_rst = ($urandom_range(0, 199) == 0);
      step();
    end
    m_rst = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Two-port round-robin APB master that shares the single APB bus (pclk domain, paddr/pwdata/prdata/psel/penable/pwrite) between two on-chip requesters, e.g. the test-sequence engine and the interrupt-service engine driving the UART. Each requester issues single read/write commands over a valid/ready handshake. The block runs the APB SETUP/ACCESS phases and returns completion plus read data on a per-port response strobe. It sits between the requesters and the APB slave (UART) and is the only driver of the APB request signals.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width

Ports:
- pclk  in  1  APB clock; all logic on posedge.
- preset  in  1  synchronous reset, active-high. The single clock is pclk; reset is synchronous and active-high.
- req0_valid  in  1  port 0 command valid
- req0_ready  out  1  port 0 command accepted (combinational)
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  command address
- req0_wdata  in  DATA_W  write data
- rsp0_valid  out  1  one-cycle completion strobe, port 0
- rsp0_rdata  out  DATA_W  read data (valid with rsp0_valid; 0 for writes)
- req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: identical to port 0, for port 1
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- prdata  in  DATA_W  APB read data, sampled at the end of ACCESS

## Operation
- FSM states:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- Transitions:
  - IDLE→SETUP on a grant, else stay in IDLE.
  - SETUP→ACCESS always.
  - ACCESS→SETUP on a grant, else ACCESS→IDLE.
  - No wait states; the slave has no pready.
- Arbitration window: only while state is IDLE or ACCESS and preset=0. reqN_ready is never high in SETUP or during reset.
- Grant rule:
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port that was not granted last.
  - The last-grant pointer updates only on a grant. Reset value = 1, so port 0 wins the first contention.
- Handshake: a command transfers when reqN_valid && reqN_ready. The requester holds valid/write/addr/wdata stable until ready.
- On a grant: paddr, pwdata and pwrite are registered from the granted port, together with the granted port id. These outputs hold their value until the next grant, including through IDLE.
- Completion:
  - At the posedge ending ACCESS, rspN_valid goes high for one cycle on the recorded port.
  - For reads, rspN_rdata gets prdata; for writes it gets 0.
  - The other port's rsp stays 0.
- There is no response backpressure; requesters must accept rsp in the cycle it is asserted.

## Timing
- Reset values: every output 0 (psel, penable, pwrite, paddr, pwdata, both ready, both rsp_valid, both rsp_rdata). State = IDLE, pointer = 1.
- Latency: command accepted in cycle T → SETUP in T+1 → ACCESS in T+2 → rsp_valid and rdata in T+3.
- Throughput:
  - Back-to-back grants in ACCESS give one transfer per 2 cycles, with psel held continuously high and penable toggling.
  - rsp of transfer n coincides with SETUP of transfer n+1.
- Reset mid-transfer: preset high in any state → on the next edge state = IDLE, psel/penable = 0, pointer = 1. No rsp_valid for the aborted transfer, including when reset is in ACCESS.
- A request dropped before ready is never issued, so no partial transfer occurs.
- prdata is sampled only at the end of ACCESS for reads and is ignored otherwise.

## Test plan
- Write via port 0: addr 0x0C, wdata 0xA5, from IDLE. req0_ready=1 in T. T+1: psel=1, penable=0, paddr=0x0C, pwrite=1, pwdata=0xA5. T+2: penable=1. T+3: rsp0_valid=1, rsp0_rdata=0, psel=0. rsp1_valid stays 0.
- Read via port 1: addr 0x04, bench drives prdata=0x1234_5678 in ACCESS. rsp1_valid=1 with rsp1_rdata=0x1234_5678 at T+3, pwrite=0 throughout.
- Contention: both ports held valid from reset release with 4 commands each. Grants are 0,1,0,1,…, psel stays high across all 8 transfers, 16 APB cycles in total. Each rsp pulse lands on the correct port, 3 cycles after its grant.
- Fairness: only port 1 valid for 3 commands, then both valid. The next grant goes to port 0.
- Handshake stall: port 0 asserts valid during SETUP. req0_ready stays 0 until ACCESS, and the command is not lost or duplicated.
- Reset during ACCESS of a read: next cycle psel=0, penable=0, no rsp. After release, a contended request is granted to port 0 first.
